// File: rtl/snake_pkg.sv
// Shared encodings and constants for the snake game sequencer slice.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam int unsigned GRID_MAX_X   = 159;
  localparam int unsigned GRID_MAX_Y   = 119;
  localparam logic [14:0] LFSR_SEED    = 15'h1ACE;
  localparam logic [7:0]  TARGET_H_RST = 8'd40;
  localparam logic [6:0]  TARGET_V_RST = 7'd30;

  // Opposite direction differs only in the MSB of the encoding.
  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_target_gen.sv
// Target position generator: free-running 15-bit LFSR folded into the grid,
// captured into TARGET_H/V on a draw strobe.
module snake_target_gen
  import snake_pkg::*;
#(
  parameter int unsigned MAX_X = GRID_MAX_X,
  parameter int unsigned MAX_Y = GRID_MAX_Y
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       draw_i,
  output logic [7:0] target_h_o,
  output logic [6:0] target_v_o
);

  logic [14:0] lfsr_q, lfsr_d;
  logic [7:0]  th_q, fold_h;
  logic [6:0]  tv_q, fold_v;

  // x^15 + x^14 + 1; never reaches zero from a nonzero seed.
  always_comb begin
    lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    fold_h = lfsr_q[7:0];
    if (fold_h > 8'(MAX_X)) fold_h = lfsr_q[7:0] - 8'(MAX_X + 1);
    fold_v = lfsr_q[14:8];
    if (fold_v > 7'(MAX_Y)) fold_v = lfsr_q[14:8] - 7'(MAX_Y + 1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
      th_q   <= TARGET_H_RST;
      tv_q   <= TARGET_V_RST;
    end else begin
      lfsr_q <= lfsr_d;
      if (draw_i) begin
        th_q <= fold_h;
        tv_q <= fold_v;
      end
    end
  end

  assign target_h_o = th_q;
  assign target_v_o = tv_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game master controller: game FSM, move tick, direction arbitration,
// scoring and target draws. Optional starvation timeout under SNAKE_TIMEOUT_EN.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned MOVE_PERIOD   = 4000000,
  parameter int unsigned WIN_SCORE     = 10,
  parameter int unsigned MAX_X         = GRID_MAX_X,
  parameter int unsigned MAX_Y         = GRID_MAX_Y,
  parameter int unsigned TIMEOUT_TICKS = 600
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U,
  input  logic       BTN_R,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       REACHED,
  input  logic       SELF_HIT,
  output logic [1:0] M_STATE,
  output logic [1:0] DIR,
  output logic       MOVE_TICK,
  output logic [7:0] TARGET_H,
  output logic [6:0] TARGET_V,
  output logic [3:0] SCORE
);

  localparam int unsigned CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  state_e           state_q;
  dir_e             dir_q, pend_q, btn_dir;
  logic [3:0]       score_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             any_btn, btn_ok, last_eat, tick_wrap, draw, timeout_hit;

  assign any_btn   = BTN_U | BTN_R | BTN_D | BTN_L;
  assign tick_wrap = (cnt_q == CNT_W'(MOVE_PERIOD - 1));
  assign last_eat  = (score_q == 4'(WIN_SCORE - 1));

  always_comb begin
    btn_dir = DIR_LEFT;
    if (BTN_U)      btn_dir = DIR_UP;
    else if (BTN_R) btn_dir = DIR_RIGHT;
    else if (BTN_D) btn_dir = DIR_DOWN;
  end

  // Reversal check is always against the committed direction, even on a tick.
  assign btn_ok = any_btn && (btn_dir != dir_opposite(dir_q));

  assign draw = ((state_q == ST_IDLE) && any_btn) ||
                ((state_q == ST_PLAY) && REACHED && !SELF_HIT && !last_eat);

`ifdef SNAKE_TIMEOUT_EN
  logic [9:0] starve_q;

  assign timeout_hit = tick_q && (starve_q == 10'(TIMEOUT_TICKS - 1));

  always_ff @(posedge CLK) begin
    if (RESET || (state_q != ST_PLAY) || REACHED) starve_q <= '0;
    else if (tick_q)                              starve_q <= starve_q + 10'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      pend_q  <= DIR_UP;
      score_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q  <= tick_wrap ? '0 : cnt_q + CNT_W'(1);
      tick_q <= tick_wrap;
      unique case (state_q)
        ST_IDLE: begin
          if (any_btn) begin
            state_q <= ST_PLAY;
            score_q <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= DIR_UP;
          end
        end
        ST_PLAY: begin
          if (tick_q) dir_q  <= pend_q;
          if (btn_ok) pend_q <= btn_dir;
          if (SELF_HIT) begin
            state_q <= ST_LOSE;
          end else if (REACHED) begin
            score_q <= score_q + 4'd1;
            if (last_eat) state_q <= ST_WIN;
          end else if (timeout_hit) begin
            state_q <= ST_LOSE;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (any_btn) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  snake_target_gen #(
    .MAX_X(MAX_X),
    .MAX_Y(MAX_Y)
  ) u_target (
    .clk_i     (CLK),
    .reset_i   (RESET),
    .draw_i    (draw),
    .target_h_o(TARGET_H),
    .target_v_o(TARGET_V)
  );

  assign M_STATE   = state_q;
  assign DIR       = dir_q;
  assign MOVE_TICK = tick_q;
  assign SCORE     = score_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer with MOVE_PERIOD=4, WIN_SCORE=3.
module tb_snake_game_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_U = 1'b0, BTN_R = 1'b0, BTN_D = 1'b0, BTN_L = 1'b0;
  logic       REACHED = 1'b0, SELF_HIT = 1'b0;
  logic [1:0] M_STATE, DIR;
  logic       MOVE_TICK;
  logic [7:0] TARGET_H;
  logic [6:0] TARGET_V;
  logic [3:0] SCORE;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_h;
  logic [6:0]  exp_v;
  logic [14:0] lfsr_m, lfsr_prev;

  snake_game_sequencer #(
    .MOVE_PERIOD  (4),
    .WIN_SCORE    (3),
    .MAX_X        (159),
    .MAX_Y        (119),
    .TIMEOUT_TICKS(5)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BTN_U    (BTN_U),
    .BTN_R    (BTN_R),
    .BTN_D    (BTN_D),
    .BTN_L    (BTN_L),
    .REACHED  (REACHED),
    .SELF_HIT (SELF_HIT),
    .M_STATE  (M_STATE),
    .DIR      (DIR),
    .MOVE_TICK(MOVE_TICK),
    .TARGET_H (TARGET_H),
    .TARGET_V (TARGET_V),
    .SCORE    (SCORE)
  );

  always #5 CLK = ~CLK;

  // Reference x^15+x^14+1 sequence; lfsr_prev is the value seen before the last edge.
  always @(posedge CLK) begin
    lfsr_prev <= lfsr_m;
    if (RESET) lfsr_m <= 15'h1ACE;
    else       lfsr_m <= {lfsr_m[13:0], lfsr_m[14] ^ lfsr_m[13]};
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic draw_expect();
    logic [7:0] h;
    logic [6:0] v;
    h = lfsr_prev[7:0];
    v = lfsr_prev[14:8];
    exp_h = (h > 8'd159) ? h - 8'd160 : h;
    exp_v = (v > 7'd119) ? v - 7'd120 : v;
  endtask

  task automatic chk_target(input string tag);
    chk({tag, "_h"}, {8'd0, TARGET_H}, {8'd0, exp_h});
    chk({tag, "_v"}, {9'd0, TARGET_V}, {9'd0, exp_v});
  endtask

  task automatic wait_tick();
    int unsigned n = 0;
    while (MOVE_TICK !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("tick_seen", {15'd0, MOVE_TICK}, 16'd1);
  endtask

  // Step through the edge that ends the next MOVE_TICK cycle.
  task automatic wait_commit();
    wait_tick();
    step();
  endtask

  task automatic pulse_reached();
    REACHED = 1'b1;
    step();
    REACHED = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    exp_h = 8'd40;
    exp_v = 7'd30;
    chk("rst_state", {14'd0, M_STATE}, 16'd0);
    chk("rst_dir", {14'd0, DIR}, 16'd0);
    chk("rst_score", {12'd0, SCORE}, 16'd0);
    chk("rst_tick", {15'd0, MOVE_TICK}, 16'd0);
    chk_target("rst_tgt");
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_tick", {15'd0, MOVE_TICK}, {15'd0, (i % 4 == 3)});
    end
    chk("idle_state", {14'd0, M_STATE}, 16'd0);
    chk_target("idle_tgt");

    // Game 1: start, direction arbitration, win.
    BTN_R = 1'b1; step(); BTN_R = 1'b0;
    draw_expect();
    chk("start_state", {14'd0, M_STATE}, 16'd1);
    chk("start_score", {12'd0, SCORE}, 16'd0);
    chk("start_dir", {14'd0, DIR}, 16'd0);
    chk_target("start_tgt");
    chk("start_range", {15'd0, (TARGET_H <= 8'd159) && (TARGET_V <= 7'd119)}, 16'd1);

    BTN_D = 1'b1; step(); BTN_D = 1'b0;
    wait_commit();
    chk("rev_drop", {14'd0, DIR}, 16'd0);

    BTN_L = 1'b1; step(); BTN_L = 1'b0;
    BTN_R = 1'b1; step(); BTN_R = 1'b0;
    chk("pend_hold", {14'd0, DIR}, 16'd0);
    wait_commit();
    chk("last_wins", {14'd0, DIR}, 16'd1);

    BTN_U = 1'b1; BTN_L = 1'b1; step(); BTN_U = 1'b0; BTN_L = 1'b0;
    wait_commit();
    chk("prio_u", {14'd0, DIR}, 16'd0);

    pulse_reached();
    draw_expect();
    chk("eat1_score", {12'd0, SCORE}, 16'd1);
    chk("eat1_state", {14'd0, M_STATE}, 16'd1);
    chk_target("eat1_tgt");
    step();
    pulse_reached();
    draw_expect();
    chk("eat2_score", {12'd0, SCORE}, 16'd2);
    chk_target("eat2_tgt");
    step();
    pulse_reached();
    chk("win_state", {14'd0, M_STATE}, 16'd2);
    chk("win_score", {12'd0, SCORE}, 16'd3);
    chk_target("win_tgt");

    REACHED = 1'b1; SELF_HIT = 1'b1; step(); REACHED = 1'b0; SELF_HIT = 1'b0;
    chk("win_ignore_state", {14'd0, M_STATE}, 16'd2);
    chk("win_ignore_score", {12'd0, SCORE}, 16'd3);

    BTN_L = 1'b1; step(); BTN_L = 1'b0;
    chk("win_to_idle", {14'd0, M_STATE}, 16'd0);
    chk("score_hold", {12'd0, SCORE}, 16'd3);

    // Game 2: press on the tick cycle, then simultaneous REACHED + SELF_HIT.
    BTN_U = 1'b1; step(); BTN_U = 1'b0;
    draw_expect();
    chk("g2_state", {14'd0, M_STATE}, 16'd1);
    chk("g2_score", {12'd0, SCORE}, 16'd0);
    chk_target("g2_tgt");

    wait_tick();
    BTN_R = 1'b1; step(); BTN_R = 1'b0;
    chk("tick_press_old", {14'd0, DIR}, 16'd0);
    wait_commit();
    chk("tick_press_new", {14'd0, DIR}, 16'd1);

    pulse_reached();
    draw_expect();
    chk("g2_eat_score", {12'd0, SCORE}, 16'd1);
    chk_target("g2_eat_tgt");
    step();
    REACHED = 1'b1; SELF_HIT = 1'b1; step(); REACHED = 1'b0; SELF_HIT = 1'b0;
    chk("both_state", {14'd0, M_STATE}, 16'd3);
    chk("both_score", {12'd0, SCORE}, 16'd1);
    chk_target("both_tgt");

    BTN_U = 1'b1; step(); BTN_U = 1'b0;
    chk("lose_to_idle", {14'd0, M_STATE}, 16'd0);

    // Game 3: reset mid-play.
    BTN_D = 1'b1; step(); BTN_D = 1'b0;
    draw_expect();
    chk("g3_state", {14'd0, M_STATE}, 16'd1);
    pulse_reached();
    step();
    pulse_reached();
    chk("g3_score", {12'd0, SCORE}, 16'd2);
    BTN_R = 1'b1; step(); BTN_R = 1'b0;
    wait_commit();
    chk("g3_dir", {14'd0, DIR}, 16'd1);

    RESET = 1'b1; step(); RESET = 1'b0;
    exp_h = 8'd40;
    exp_v = 7'd30;
    chk("mid_rst_state", {14'd0, M_STATE}, 16'd0);
    chk("mid_rst_dir", {14'd0, DIR}, 16'd0);
    chk("mid_rst_score", {12'd0, SCORE}, 16'd0);
    chk("mid_rst_tick", {15'd0, MOVE_TICK}, 16'd0);
    chk_target("mid_rst_tgt");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_tick", {15'd0, MOVE_TICK}, {15'd0, (i == 3)});
    end

`ifdef SNAKE_TIMEOUT_EN
    BTN_U = 1'b1; step(); BTN_U = 1'b0;
    chk("to_start", {14'd0, M_STATE}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      wait_commit();
      chk("to_alive", {14'd0, M_STATE}, 16'd1);
    end
    wait_commit();
    chk("timeout_lose", {14'd0, M_STATE}, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
